// File: rtl/fft_cap_pkg.sv
// Shared types and helpers for the FFT output-frame capture block:
// FSM state encoding, magnitude width derivation and the L1 magnitude function.
package fft_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } cap_state_e;

    // Widest sample the helpers accept; narrower samples are sign-extended into it.
    localparam int DW_MAX = 32;

    function automatic int mag_width(input int dw);
        return dw + 1;
    endfunction

    // |v| without saturation: the most negative narrow value maps to +2^(DW-1).
    function automatic logic [DW_MAX-1:0] abs_val(input logic signed [DW_MAX-1:0] v);
        return v[DW_MAX-1] ? -v : v;
    endfunction

    function automatic logic [DW_MAX:0] l1_mag(input logic signed [DW_MAX-1:0] re,
                                               input logic signed [DW_MAX-1:0] im);
        return {1'b0, abs_val(re)} + {1'b0, abs_val(im)};
    endfunction

endpackage

// File: rtl/fft_cap_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read-before-write on an address collision, so it maps onto block RAM.
module fft_cap_ram
    import fft_cap_pkg::*;
#(
    parameter int AW = 8,
    parameter int WW = 49
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem [2**AW];
    logic [WW-1:0] rdata_q;
    logic [WW-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Output register uses the block RAM's output reset so readout is zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_capture.sv
// Captures one FFT output frame into a buffer indexed by bin, tracking the
// L1-magnitude peak on the fly, then holds it for random-access readout.
module fft_frame_capture
    import fft_cap_pkg::*;
#(
    parameter  int POINTS_LOG = 8,
    parameter  int DW         = 16,
    localparam int MW         = mag_width(DW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  soud,
    input  logic                  opd,
    input  logic                  eoud,
    input  logic [POINTS_LOG-1:0] idx,
    input  logic signed [DW-1:0]  xk_re,
    input  logic signed [DW-1:0]  xk_im,
    input  logic [POINTS_LOG-1:0] rd_addr,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic signed [DW-1:0]  rd_re,
    output logic signed [DW-1:0]  rd_im,
    output logic [MW-1:0]         rd_mag,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [POINTS_LOG-1:0] peak_idx,
    output logic [MW-1:0]         peak_mag
);

    localparam int WW = 2 * DW + MW;
    // Two spare count bits so an over-long frame saturates above FULL instead of wrapping.
    localparam int CW = POINTS_LOG + 2;
    localparam logic [CW-1:0] FULL = CW'(1) << POINTS_LOG;

    cap_state_e            state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [POINTS_LOG-1:0] peak_idx_q, peak_idx_d;
    logic [MW-1:0]         peak_mag_q, peak_mag_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rd_vld_p1_q, rd_vld_p1_d;

    logic [MW-1:0]         mag_p0;
    logic                  take_p0;
    logic [WW-1:0]         rd_word_p1;

    assign mag_p0 = MW'(l1_mag(DW_MAX'(xk_re), DW_MAX'(xk_im)));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        peak_idx_d   = peak_idx_q;
        peak_mag_d   = peak_mag_q;
        frame_done_d = frame_done_q;
        frame_err_d  = frame_err_q;
        take_p0      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d      = WAIT;
                    frame_done_d = 1'b0;
                    frame_err_d  = 1'b0;
                end
            end
            WAIT, CAP: begin
                if (opd && (soud || state_q == CAP)) begin
                    take_p0 = 1'b1;
                    if (soud) begin
                        // A start marker mid-capture means the previous run was cut short.
                        count_d    = CW'(1);
                        peak_idx_d = idx;
                        peak_mag_d = mag_p0;
                        if (state_q == CAP) begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        if (count_q <= FULL) begin
                            count_d = count_q + CW'(1);
                        end
                        if (mag_p0 > peak_mag_q) begin
                            peak_idx_d = idx;
                            peak_mag_d = mag_p0;
                        end
                    end
                    if (eoud) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                        if (count_d != FULL) begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        state_d = CAP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_vld_p1_d = rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            peak_idx_q   <= '0;
            peak_mag_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_vld_p1_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            peak_idx_q   <= peak_idx_d;
            peak_mag_q   <= peak_mag_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
        end
    end

    // ---- p0 -> p1: buffer write and registered readout ----
    fft_cap_ram #(
        .AW (POINTS_LOG),
        .WW (WW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (take_p0),
        .waddr (idx),
        .wdata ({xk_re, xk_im, mag_p0}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_word_p1)
    );

    assign rd_valid   = rd_vld_p1_q;
    assign rd_re      = rd_word_p1[WW-1 -: DW];
    assign rd_im      = rd_word_p1[MW +: DW];
    assign rd_mag     = rd_word_p1[MW-1:0];
    assign busy       = (state_q == WAIT) || (state_q == CAP);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign peak_idx   = peak_idx_q;
    assign peak_mag   = peak_mag_q;

endmodule

// File: doc/fft_frame_capture.md
# fft_frame_capture

Sink for the FFT core's output stream: captures one complete output frame (soud/opd/eoud, idx, xk_re, xk_im) into an internal dual-port buffer indexed by idx. While capturing, it computes a per-bin L1 magnitude and tracks the peak bin. It then holds the frame for random-access readout by the LED/probe/host logic in the FFT test top. It sits directly after the FFT core on the FFT clock domain.

## Interface
Parameters:
- POINTS_LOG, 8, log2 of FFT points; buffer depth 2^POINTS_LOG
- DW, 16, width of signed xk_re/xk_im
- MW, DW+1, magnitude width (derived, not overridden)

Ports:
- clk  in  1  FFT clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  one-cycle pulse; arm capture of next frame
- soud  in  1  FFT start-of-output-data
- opd  in  1  FFT output-data valid
- eoud  in  1  FFT end-of-output-data
- idx  in  POINTS_LOG  bin index of current output sample
- xk_re  in  DW  signed real part
- xk_im  in  DW  signed imaginary part
- rd_addr  in  POINTS_LOG  readout bin address
- rd_en  in  1  readout request
- rd_valid  out  1  readout data valid
- rd_re  out  DW  stored real part
- rd_im  out  DW  stored imaginary part
- rd_mag  out  MW  stored magnitude
- busy  out  1  high in WAIT or CAP
- frame_done  out  1  level; valid frame held
- frame_err  out  1  sticky error for last capture
- peak_idx  out  POINTS_LOG  bin of largest magnitude
- peak_mag  out  MW  largest magnitude

## Operation
- States: IDLE, WAIT (armed, waiting for soud), CAP (capturing), DONE.
- IDLE/DONE + arm -> WAIT; clears frame_done and frame_err. arm in WAIT/CAP is ignored.
- WAIT: opd without soud is ignored. soud&opd -> CAP. That sample is written; count=1; peak initialised to it.
- CAP: each opd writes {re, im, mag} to mem[idx] and increments count. Peak updates only if mag > peak_mag (strict), so ties keep the earliest-arriving bin.
- eoud&opd in CAP: write the last sample, then go to DONE with frame_done=1. frame_err=1 if count (including this sample) != 2^POINTS_LOG.
- soud&opd in CAP (restart): set frame_err, restart count and peak from this sample, stay in CAP.
- Magnitude: mag = |re| + |im|, computed in MW bits. |−2^(DW−1)| = 2^(DW−1) exactly; no saturation. Max value 2^DW.
- Reads are allowed in any state. Reading an address written in the same cycle returns old data.

## Timing
- Reset values: state IDLE; busy 0, frame_done 0, frame_err 0, peak_idx 0, peak_mag 0, rd_valid 0, rd_re/rd_im/rd_mag 0. Buffer contents are undefined after reset.
- Write: sample is in mem the cycle after opd.
- Peak: peak_idx/peak_mag reflect sample n one cycle after its opd.
- frame_done rises one cycle after the eoud&opd cycle. peak outputs are final by then.
- Read latency is 1: rd_en in cycle t -> rd_valid and data in cycle t+1. rd_valid is a single-cycle pulse per request; back-to-back requests give back-to-back data.
- Asynchronous reset mid-capture aborts immediately to IDLE; no partial frame_done.

## Structure
- Shared package fft_cap_pkg: state enum (IDLE, WAIT, CAP, DONE), MW derivation, and abs/L1-magnitude function.
- One sub-module, fft_cap_ram: simple dual-port RAM, width 2·DW+MW, depth 2^POINTS_LOG, synchronous read, inferable as Gowin BSRAM.
- FSM, counters and peak tracker live in the top module.

## Test plan
- Full frame (POINTS_LOG=3): arm, then 8 samples idx 0..7, re=idx, im=−idx, eoud on idx 7 -> frame_done=1 one cycle later, frame_err=0, peak_idx=7, peak_mag=14; reading addr 3 gives re=3, im=−3, mag=6 with 1-cycle latency.
- Tie and extreme values: bins 2 and 5 both mag 40; bin 6 re=−32768, im=0 (DW=16) -> peak_idx=6, peak_mag=32768. Without bin 6 -> peak_idx=2.
- Short frame: eoud after 5 samples -> frame_done=1, frame_err=1.
- Unarmed/WAIT filtering: stream while IDLE -> no writes, frame_done stays 0. Arm mid-stream -> capture starts only at the next soud.
- Restart: second soud at sample 4 -> frame_err=1, peak reflects only the second run, count restarts.
- Reset mid-CAP: deassert rst_n at sample 3 -> all outputs at reset values asynchronously. Re-arm and a full frame then completes cleanly.
